// File: rtl/i2s_slave_rx_deser_if.sv
// Signal bundle between the I2S receiver and its surroundings: pad-level I2S
// inputs, FIFO/control strobes, and the FIFO, DMA, interrupt and debug outputs.
interface i2s_slave_rx_deser_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                    I2S_CLK_i;
  logic                    I2S_WS_CLK_i;
  logic                    I2S_DIN_i;
  logic                    I2S_En_i;
  logic                    Fifo_Flush_i;
  logic                    Rx_Pop_i;
  logic                    Ovfl_Clr_i;
  logic [2*DATA_WIDTH-1:0] Rx_Data_o;
  logic                    Rx_Empty_o;
  logic [LW-1:0]           Rx_Level_o;
  logic                    Rx_Ovfl_o;
  logic                    SDMA_Req_I2S_o;
  logic                    I2S_RX_Intr_o;
  logic [7:0]              rx_debug_o;

  modport master (
    output I2S_CLK_i, I2S_WS_CLK_i, I2S_DIN_i, I2S_En_i,
           Fifo_Flush_i, Rx_Pop_i, Ovfl_Clr_i,
    input  Rx_Data_o, Rx_Empty_o, Rx_Level_o, Rx_Ovfl_o,
           SDMA_Req_I2S_o, I2S_RX_Intr_o, rx_debug_o
  );

  modport slave (
    input  I2S_CLK_i, I2S_WS_CLK_i, I2S_DIN_i, I2S_En_i,
           Fifo_Flush_i, Rx_Pop_i, Ovfl_Clr_i,
    output Rx_Data_o, Rx_Empty_o, Rx_Level_o, Rx_Ovfl_o,
           SDMA_Req_I2S_o, I2S_RX_Intr_o, rx_debug_o
  );
endinterface

// File: rtl/i2s_slave_rx_deser.sv
// Oversampled I2S slave receiver: deserializes stereo pairs into a FWFT FIFO
// that drives the DMA request and RX interrupt. Define I2S_RX_DBG_EN for rx_debug_o.
module i2s_slave_rx_deser #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DMA_THRESH = 4
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST_n,
  i2s_slave_rx_deser_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  // [0], [1] synchronize; [2] is the history stage
  logic [2:0] sck_q, ws_q, din_q;
  logic       sck_rise;

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      sck_q <= '0;
      ws_q  <= '0;
      din_q <= '0;
    end else begin
      sck_q <= {sck_q[1:0], bus.I2S_CLK_i};
      ws_q  <= {ws_q[1:0],  bus.I2S_WS_CLK_i};
      din_q <= {din_q[1:0], bus.I2S_DIN_i};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];

  // WS/DIN are taken one stage later than SCK so they were settled before the edge
  logic smp_valid, smp_ws, smp_din;

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      smp_valid <= 1'b0;
      smp_ws    <= 1'b0;
      smp_din   <= 1'b0;
    end else begin
      smp_valid <= sck_rise;
      if (sck_rise) begin
        smp_ws  <= ws_q[2];
        smp_din <= din_q[2];
      end
    end
  end

  state_t                  state;
  logic                    ws_prev;
  logic [DATA_WIDTH-1:0]   shift;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   left_hold;
  logic                    push_req;
  logic [2*DATA_WIDTH-1:0] push_data;

  logic                    boundary;
  logic                    cnt_full;
  logic [CW-1:0]           nbits;
  logic [DATA_WIDTH-1:0]   word_raw;
  logic [DATA_WIDTH-1:0]   word;

  // Closing word: boundary LSB joins unless saturated, then left-justify short words
  always_comb begin
    boundary = smp_valid & (smp_ws != ws_prev);
    cnt_full = (cnt >= CW'(DATA_WIDTH));
    word_raw = {shift[DATA_WIDTH-2:0], smp_din};
    nbits    = cnt + CW'(1);
    if (cnt_full) begin
      word_raw = shift;
      nbits    = CW'(DATA_WIDTH);
    end
    word = word_raw << (CW'(DATA_WIDTH) - nbits);
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      state     <= IDLE;
      ws_prev   <= 1'b0;
      shift     <= '0;
      cnt       <= '0;
      left_hold <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= 1'b0;
      if (smp_valid) ws_prev <= smp_ws;
      if (!bus.I2S_En_i) begin
        state     <= IDLE;
        shift     <= '0;
        cnt       <= '0;
        left_hold <= '0;
      end else begin
        case (state)
          IDLE: begin
            state     <= SYNC;
            shift     <= '0;
            cnt       <= '0;
            left_hold <= '0;
          end
          SYNC: begin
            if (boundary && ws_prev) begin
              state <= RUN;
              shift <= '0;
              cnt   <= '0;
            end
          end
          RUN: begin
            if (boundary) begin
              shift <= '0;
              cnt   <= '0;
              if (!ws_prev) begin
                left_hold <= word;
              end else begin
                push_req  <= 1'b1;
                push_data <= {left_hold, word};
              end
            end else if (smp_valid && !cnt_full) begin
              shift <= {shift[DATA_WIDTH-2:0], smp_din};
              cnt   <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           level;
  logic                    ovfl, dma_req, intr;
  logic                    empty, full, do_push, do_pop, drop;

  always_comb begin
    empty   = (level == '0);
    full    = (level == LW'(FIFO_DEPTH));
    do_pop  = bus.Rx_Pop_i & ~empty;
    do_push = push_req & (~full | do_pop);
    drop    = push_req & full & ~do_pop;
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovfl    <= 1'b0;
      dma_req <= 1'b0;
      intr    <= 1'b0;
    end else begin
      if (bus.Fifo_Flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + AW'(1);
        if (do_push && !do_pop)      level <= level + LW'(1);
        else if (!do_push && do_pop) level <= level - LW'(1);
      end
      // A new overflow outranks a simultaneous clear
      if (drop && !bus.Fifo_Flush_i) ovfl <= 1'b1;
      else if (bus.Ovfl_Clr_i)       ovfl <= 1'b0;
      dma_req <= (level >= LW'(DMA_THRESH));
      intr    <= (level >= LW'(DMA_THRESH)) & ~dma_req;
    end
  end

  assign bus.Rx_Data_o      = mem[rd_ptr];
  assign bus.Rx_Empty_o     = empty;
  assign bus.Rx_Level_o     = level;
  assign bus.Rx_Ovfl_o      = ovfl;
  assign bus.SDMA_Req_I2S_o = dma_req;
  assign bus.I2S_RX_Intr_o  = intr;

`ifdef I2S_RX_DBG_EN
  logic [3:0] dbg_cnt;
  always_comb dbg_cnt = (32'(cnt) > 15) ? 4'hF : 4'(cnt);
  assign bus.rx_debug_o = {state, ws_q[2], sck_rise, dbg_cnt};
`else
  assign bus.rx_debug_o = 8'h00;
`endif

endmodule

// File: tb/tb_i2s_slave_rx_deser.sv
// Directed bench for i2s_slave_rx_deser: drives I2S frames at 6+ WB_CLK per bit
// and checks FIFO contents, flags, DMA request/interrupt and reset behaviour.
module tb_i2s_slave_rx_deser;
  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int THRESH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_slave_rx_deser_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  i2s_slave_rx_deser #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .DMA_THRESH(THRESH)
  ) dut (
    .WB_CLK  (clk),
    .WB_RST_n(rst_n),
    .bus     (bus)
  );

  int tests_run = 0;
  int failures  = 0;
  int intr_seen = 0;
  int intr_base = 0;

  always @(negedge clk) if (bus.I2S_RX_Intr_o === 1'b1) intr_seen = intr_seen + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic ws, input logic d);
    @(negedge clk);
    bus.I2S_CLK_i    = 1'b0;
    bus.I2S_WS_CLK_i = ws;
    bus.I2S_DIN_i    = d;
    repeat (2) @(negedge clk);
    bus.I2S_CLK_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bits(input logic ws, input int n, input logic [31:0] val);
    for (int i = n - 1; i >= 0; i--) send_bit(ws, val[i]);
  endtask

  // n-bit word on channel ws; its LSB rides on the edge where WS flips
  task automatic send_word(input logic ws, input int n, input logic [31:0] val);
    send_bits(ws, n - 1, val >> 1);
    send_bit(~ws, val[0]);
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    send_word(1'b0, 16, {16'h0, l});
    send_word(1'b1, 16, {16'h0, r});
    repeat (6) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) bus.Rx_Pop_i = 1'b1;
    @(negedge clk) bus.Rx_Pop_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.I2S_CLK_i    = 1'b0;
    bus.I2S_WS_CLK_i = 1'b0;
    bus.I2S_DIN_i    = 1'b0;
    bus.I2S_En_i     = 1'b0;
    bus.Fifo_Flush_i = 1'b0;
    bus.Rx_Pop_i     = 1'b0;
    bus.Ovfl_Clr_i   = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_data",  bus.Rx_Data_o, 32'h0);
    check_eq("rst_empty", bus.Rx_Empty_o, 1'b1);
    check_eq("rst_level", bus.Rx_Level_o, 4'd0);
    check_eq("rst_ovfl",  bus.Rx_Ovfl_o, 1'b0);
    check_eq("rst_req",   bus.SDMA_Req_I2S_o, 1'b0);
    check_eq("rst_intr",  bus.I2S_RX_Intr_o, 1'b0);
    check_eq("rst_dbg",   bus.rx_debug_o, 8'h00);

    rst_n = 1'b1;
    @(negedge clk) bus.I2S_En_i = 1'b1;
    repeat (2) @(negedge clk);

    // Sync frame, then left A5C3 and right 1234 with the closing edge timed by hand
    send_word(1'b0, 16, 32'h0000_0F0F);
    send_word(1'b1, 16, 32'h0000_3C3C);
    send_word(1'b0, 16, 32'h0000_A5C3);
    send_bits(1'b1, 15, 32'h0000_1234 >> 1);
    @(negedge clk);
    bus.I2S_CLK_i = 1'b0; bus.I2S_WS_CLK_i = 1'b0; bus.I2S_DIN_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.I2S_CLK_i = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("lat_empty_3cyc", bus.Rx_Empty_o, 1'b1);
    @(negedge clk);
    check_eq("lat_empty_4cyc", bus.Rx_Empty_o, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("basic_data",  bus.Rx_Data_o, 32'hA5C3_1234);
    check_eq("basic_level", bus.Rx_Level_o, 4'd1);
    check_eq("basic_req",   bus.SDMA_Req_I2S_o, 1'b0);
    pop_one();
    check_eq("basic_pop_empty", bus.Rx_Empty_o, 1'b1);

    // 24-bit left truncates to MSBs, 12-bit right pads with zeros
    send_word(1'b0, 24, 32'h00AB_CDEF);
    send_word(1'b1, 12, 32'h0000_0FFF);
    repeat (6) @(negedge clk);
    check_eq("trunc_pad_data",  bus.Rx_Data_o, 32'hABCD_FFF0);
    check_eq("trunc_pad_level", bus.Rx_Level_o, 4'd1);
    pop_one();

    intr_base = intr_seen;
    for (int i = 0; i < 4; i++) begin
      send_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
      if (i == 2) check_eq("thr_req_below", bus.SDMA_Req_I2S_o, 1'b0);
    end
    check_eq("thr_level",  bus.Rx_Level_o, 4'd4);
    check_eq("thr_req",    bus.SDMA_Req_I2S_o, 1'b1);
    check_eq("thr_intr_n", intr_seen - intr_base, 1);
    check_eq("thr_head0",  bus.Rx_Data_o, 32'h1000_2000);
    pop_one();
    check_eq("thr_pop_level", bus.Rx_Level_o, 4'd3);
    check_eq("thr_pop_req",   bus.SDMA_Req_I2S_o, 1'b0);
    check_eq("thr_head1",     bus.Rx_Data_o, 32'h1001_2001);
    @(negedge clk) bus.Fifo_Flush_i = 1'b1;
    @(negedge clk) bus.Fifo_Flush_i = 1'b0;
    @(negedge clk);
    check_eq("flush_level", bus.Rx_Level_o, 4'd0);
    check_eq("flush_empty", bus.Rx_Empty_o, 1'b1);

    intr_base = intr_seen;
    for (int i = 0; i < 9; i++) send_pair(16'hC000 + 16'(i), 16'hD000 + 16'(i));
    check_eq("ovf_level",  bus.Rx_Level_o, 4'd8);
    check_eq("ovf_flag",   bus.Rx_Ovfl_o, 1'b1);
    check_eq("ovf_head",   bus.Rx_Data_o, 32'hC000_D000);
    check_eq("ovf_intr_n", intr_seen - intr_base, 1);
    @(negedge clk) bus.Ovfl_Clr_i = 1'b1;
    @(negedge clk) bus.Ovfl_Clr_i = 1'b0;
    check_eq("ovf_clr", bus.Rx_Ovfl_o, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("ovf_drain%0d", i), bus.Rx_Data_o,
               {16'hC000 + 16'(i), 16'hD000 + 16'(i)});
      pop_one();
    end
    check_eq("drain_empty", bus.Rx_Empty_o, 1'b1);
    pop_one();
    check_eq("pop_empty_level", bus.Rx_Level_o, 4'd0);

    // Enable lands mid-left-word: that frame must not be pushed
    @(negedge clk) bus.I2S_En_i = 1'b0;
    repeat (3) @(negedge clk);
    send_bits(1'b0, 8, 32'h0000_00AA);
    bus.I2S_En_i = 1'b1;
    send_word(1'b0, 8, 32'h0000_0055);
    send_word(1'b1, 16, 32'h0000_7777);
    repeat (6) @(negedge clk);
    check_eq("midEn_nopush", bus.Rx_Level_o, 4'd0);
    send_pair(16'h1357, 16'h2468);
    check_eq("midEn_level", bus.Rx_Level_o, 4'd1);
    check_eq("midEn_head",  bus.Rx_Data_o, 32'h1357_2468);

    // Disable mid-right-word: pair dropped, FIFO kept
    send_word(1'b0, 16, 32'h0000_9999);
    send_bits(1'b1, 8, 32'h0000_0012);
    bus.I2S_En_i = 1'b0;
    repeat (3) @(negedge clk);
    send_word(1'b1, 8, 32'h0000_0034);
    repeat (6) @(negedge clk);
    check_eq("dis_level", bus.Rx_Level_o, 4'd1);
    check_eq("dis_head",  bus.Rx_Data_o, 32'h1357_2468);

    // Re-enabled receiver resynchronises: first pair only establishes alignment
    bus.I2S_En_i = 1'b1;
    send_pair(16'hDEAD, 16'hBEEF);
    check_eq("reen_sync_nopush", bus.Rx_Level_o, 4'd1);
    send_pair(16'h0F0F, 16'hF0F0);
    check_eq("reen_level", bus.Rx_Level_o, 4'd2);
    send_pair(16'h5A5A, 16'hA5A5);
    check_eq("prerst_level", bus.Rx_Level_o, 4'd3);

    send_bits(1'b0, 5, 32'h0000_0015);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_empty", bus.Rx_Empty_o, 1'b1);
    check_eq("arst_level", bus.Rx_Level_o, 4'd0);
    check_eq("arst_data",  bus.Rx_Data_o, 32'h0);
    check_eq("arst_ovfl",  bus.Rx_Ovfl_o, 1'b0);
    check_eq("arst_req",   bus.SDMA_Req_I2S_o, 1'b0);
    check_eq("arst_intr",  bus.I2S_RX_Intr_o, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("post_rst_empty", bus.Rx_Empty_o, 1'b1);
    check_eq("post_rst_level", bus.Rx_Level_o, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
